regfile_scoreboard: RTL

//  Architectural integer register file plus per-register pending-write scoreboard; responder end of the writeback

---
 rtl/regfile_scoreboard_pkg.sv | 24 ++
 rtl/regfile_pend_ctr.sv | 44 ++++
 rtl/regfile_scoreboard.sv | 86 ++++++++
 3 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and counter-op encoding for the register file / pending-write scoreboard.
package regfile_scoreboard_pkg;

  localparam int REG_ADDR_SIZE   = 4;
  localparam int REG_DATA_SIZE   = 31;
  localparam int DEF_PEND_BITS   = 2;
  localparam int DEF_NREGS       = 32;

  typedef enum logic [1:0] {
    CTR_HOLD,
    CTR_INC,
    CTR_DEC,
    CTR_CLR
  } ctr_op_e;

  // Flush dominates; a simultaneous issue and commit cancel out.
  function automatic ctr_op_e ctrOp(input logic clr, input logic inc, input logic dec);
    if (clr)             return CTR_CLR;
    else if (inc && !dec) return CTR_INC;
    else if (dec && !inc) return CTR_DEC;
    else                 return CTR_HOLD;
  endfunction

endpackage

// File: rtl/regfile_pend_ctr.sv
// Per-register pending-writer counter: saturating up/down with synchronous clear.
module regfile_pend_ctr
  import regfile_scoreboard_pkg::*;
#(
  parameter int W = DEF_PEND_BITS
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_max,
  output logic         o_zero
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_cnt;
  logic         w_dec;
  logic         w_inc;

  // A commit with nothing pending must not underflow; an issue at MAX only lands if a commit frees a slot.
  assign w_dec = i_dec && (r_cnt != '0);
  assign w_inc = i_inc && ((r_cnt != MAX) || w_dec);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      case (ctrOp(i_clr, w_inc, w_dec))
        CTR_CLR:  r_cnt <= '0;
        CTR_INC:  r_cnt <= r_cnt + W'(1);
        CTR_DEC:  r_cnt <= r_cnt - W'(1);
        default:  r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_cnt  = r_cnt;
  assign o_max  = (r_cnt == MAX);
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through read ports and a per-register pending-writer scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN      = REG_DATA_SIZE + 1,
  parameter int NREGS     = DEF_NREGS,
  parameter int PEND_BITS = DEF_PEND_BITS,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [AW-1:0]   i_rs1_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic            o_rs1_busy,
  input  logic [AW-1:0]   i_rs2_addr,
  output logic [XLEN-1:0] o_rs2_data,
  output logic            o_rs2_busy,
  input  logic            i_issue_valid,
  input  logic [AW-1:0]   i_issue_rd,
  output logic            o_issue_ready,
  input  logic            i_wr_enable,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data,
  input  logic            i_flush
);

  logic [XLEN-1:0]      r_regs [1:NREGS-1];
  logic [PEND_BITS-1:0] w_cnt  [NREGS];
  logic [NREGS-1:0]     w_max;
  logic [NREGS-1:0]     w_zero;
  logic                 w_issueFire;
  logic                 w_rs1Dec;
  logic                 w_rs2Dec;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_wr_enable && (i_wr_addr != '0)) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  assign w_cnt[0]  = '0;
  assign w_max[0]  = 1'b0;
  assign w_zero[0] = 1'b1;

  assign o_issue_ready = !((i_issue_rd != '0) && w_max[i_issue_rd] &&
                           !(i_wr_enable && (i_wr_addr == i_issue_rd)));
  assign w_issueFire   = i_issue_valid && o_issue_ready;

  for (genvar r = 1; r < NREGS; r++) begin : g_ctr
    regfile_pend_ctr #(.W(PEND_BITS)) u_ctr (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_inc  (w_issueFire && (i_issue_rd == AW'(r))),
      .i_dec  (i_wr_enable && (i_wr_addr == AW'(r))),
      .i_clr  (i_flush),
      .o_cnt  (w_cnt[r]),
      .o_max  (w_max[r]),
      .o_zero (w_zero[r])
    );
  end

  always_comb begin
    o_rs1_data = '0;
    if (i_rs1_addr == '0)                              o_rs1_data = '0;
    else if (i_wr_enable && (i_wr_addr == i_rs1_addr)) o_rs1_data = i_wr_data;
    else                                               o_rs1_data = r_regs[i_rs1_addr];
  end

  always_comb begin
    o_rs2_data = '0;
    if (i_rs2_addr == '0)                              o_rs2_data = '0;
    else if (i_wr_enable && (i_wr_addr == i_rs2_addr)) o_rs2_data = i_wr_data;
    else                                               o_rs2_data = r_regs[i_rs2_addr];
  end

  // A writer committing this cycle is served by the bypass, so it no longer counts as pending.
  assign w_rs1Dec   = i_wr_enable && (i_wr_addr == i_rs1_addr) && !w_zero[i_rs1_addr];
  assign w_rs2Dec   = i_wr_enable && (i_wr_addr == i_rs2_addr) && !w_zero[i_rs2_addr];
  assign o_rs1_busy = (i_rs1_addr != '0) && !w_zero[i_rs1_addr] &&
                      !(w_rs1Dec && (w_cnt[i_rs1_addr] == PEND_BITS'(1)));
  assign o_rs2_busy = (i_rs2_addr != '0) && !w_zero[i_rs2_addr] &&
                      !(w_rs2Dec && (w_cnt[i_rs2_addr] == PEND_BITS'(1)));

endmodule
